// File: rtl/march_bist_ctrl.sv
// March C- self-test controller for a 2^ADDR_W x DATA_W synchronous SRAM.
// Owns the SRAM port while busy and captures the first miscompare.
module march_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter logic [DATA_W-1:0] DATA_BG = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);
  // state | meaning
  // IDLE  | waiting for start, SRAM port parked
  // RUN   | issuing March C- operations, one per cycle
  // TAIL  | compare of the final E5 read in flight
  // DONE  | result held until next start
  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [DATA_W-1:0] DATA_INV = ~DATA_BG;

  state_t            state, state_nxt;
  logic [2:0]        elem;
  logic [ADDR_W-1:0] addr;
  logic              phase;
  logic              start_run;

  logic              two_op, down, next_down, is_read, last_addr, elem_end, last_op;
  logic [DATA_W-1:0] read_pat, write_pat;

  logic              rd_vld;
  logic [DATA_W-1:0] rd_exp;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_elem;

  // E0 and E5 are single-op; E1..E4 do read then write on each address.
  always_comb begin
    two_op    = (elem != 3'd0) && (elem != 3'd5);
    down      = (elem == 3'd3) || (elem == 3'd4);
    next_down = (elem == 3'd2) || (elem == 3'd3);
    is_read   = (elem != 3'd0) && !(two_op && phase);
    last_addr = down ? (addr == '0) : (addr == ADDR_MAX);
    elem_end  = last_addr && (!two_op || phase);
    last_op   = elem_end && (elem == 3'd5);
    read_pat  = ((elem == 3'd2) || (elem == 3'd4)) ? DATA_INV : DATA_BG;
    write_pat = ((elem == 3'd1) || (elem == 3'd3)) ? DATA_INV : DATA_BG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_d     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        mem_addr = addr;
        if (!is_read) begin
          mem_we = 1'b1;
          mem_d  = write_pat;
        end
        if (last_op) state_nxt = TAIL;
      end
      TAIL: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      rd_vld    <= 1'b0;
      rd_exp    <= '0;
      rd_addr   <= '0;
      rd_elem   <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      rd_vld <= (state == RUN) && is_read;
      if ((state == RUN) && is_read) begin
        rd_exp  <= read_pat;
        rd_addr <= addr;
        rd_elem <= elem;
      end

      // Only the first miscompare of a run is captured.
      if (rd_vld && (mem_q != rd_exp)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= rd_addr;
          fail_elem <= rd_elem;
          fail_data <= rd_exp ^ mem_q;
        end
      end

      if (start_run) begin
        elem      <= '0;
        addr      <= '0;
        phase     <= 1'b0;
        rd_vld    <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else if (state == RUN) begin
        if (two_op && !phase) begin
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (elem_end) begin
            elem <= elem + 3'd1;
            addr <= next_down ? ADDR_MAX : '0;
          end else begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: SRAM with injectable stuck-at cell, cycle-level
// reference model of the March C- schedule, and directed plus random runs.
module tb_march_bist_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_q = 4'h0;
  logic [7:0] mem_addr;
  logic [3:0] mem_d;
  logic       mem_we;
  logic       busy, done, fail;
  logic [7:0] fail_addr;
  logic [2:0] fail_elem;
  logic [3:0] fail_data;

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(4), .DATA_BG(4'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_q(mem_q),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM with one optional stuck-at cell (forced bits seen on read)
  logic [3:0] mem [256];
  bit         f_en = 0;
  int         f_addr = 0;
  logic [3:0] f_mask = 4'h0;
  logic [3:0] f_val = 4'h0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_d;
    else if (f_en && int'(mem_addr) == f_addr)
      mem_q <= (mem[mem_addr] & ~f_mask) | (f_val & f_mask);
    else
      mem_q <= mem[mem_addr];
  end

  // March C- schedule: "1" means ~background for the pattern of each element
  bit rd_one [6] = '{0, 0, 1, 0, 1, 0};
  bit wr_one [6] = '{0, 1, 0, 1, 0, 0};

  // Operation performed in run cycle n (1..2560)
  function automatic void op_at(input int n, output int e, output int a,
                                output bit wr, output logic [3:0] pat);
    int m, r;
    if (n <= 256) begin
      e = 0; a = n - 1; wr = 1;
    end else if (n <= 2304) begin
      m = n - 257; e = 1 + m / 512; r = m % 512; a = r / 2;
      if (e == 3 || e == 4) a = 255 - a;
      wr = (r % 2) == 1;
    end else begin
      e = 5; a = n - 2305; wr = 0;
    end
    pat = (wr ? wr_one[e] : rd_one[e]) ? 4'hF : 4'h0;
  endfunction

  // Reference model: 0 idle, 1 running (m_n = current cycle), 2 done
  int         m_state = 0;
  int         m_n = 0;
  bit         m_fail = 0;
  int         m_faddr = 0;
  int         m_felem = 0;
  logic [3:0] m_fdata = 4'h0;

  initial begin
    int e, a;
    bit wr;
    logic [3:0] pat, act;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_n = 0; m_fail = 0; m_faddr = 0; m_felem = 0; m_fdata = 0;
      end else if (m_state != 1) begin
        if (start) begin
          m_state = 1; m_n = 1; m_fail = 0; m_faddr = 0; m_felem = 0; m_fdata = 0;
        end
      end else begin
        m_n++;
        if (m_n == 2562) m_state = 2;
        if (m_n >= 3 && m_n - 2 <= 2560) begin
          op_at(m_n - 2, e, a, wr, pat);
          if (!wr && f_en && a == f_addr) begin
            act = (pat & ~f_mask) | (f_val & f_mask);
            if (act != pat && !m_fail) begin
              m_fail = 1; m_faddr = a; m_felem = e; m_fdata = act ^ pat;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    int e, a, ea;
    bit wr, ewe, eb, ed_one;
    logic [3:0] pat, ed;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        eb = 0; ewe = 0; ea = 0; ed = 4'h0; ed_one = (m_state == 2);
        if (m_state == 1) begin
          eb = 1;
          if (m_n <= 2560) begin
            op_at(m_n, e, a, wr, pat);
            ewe = wr; ea = a; ed = wr ? pat : 4'h0;
          end
        end
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_addr", 32'(mem_addr), ea);
        check("mem_d", 32'(mem_d), 32'(ed));
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed_one));
        check("fail", 32'(fail), 32'(m_fail));
        check("fail_addr", 32'(fail_addr), m_faddr);
        check("fail_elem", 32'(fail_elem), m_felem);
        check("fail_data", 32'(fail_data), 32'(m_fdata));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_d"}, 32'(mem_d), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 0);
    check({tag, "_fail_elem"}, 32'(fail_elem), 0);
    check({tag, "_fail_data"}, 32'(fail_data), 0);
  endtask

  // Pulse start, then observe each cycle c (counted from the start edge).
  task automatic run_test(input int pulse_at, input int rst_at,
                          output int fail_cyc, output int done_cyc,
                          output int n_wr, output int n_rd);
    fail_cyc = 0; done_cyc = 0; n_wr = 0; n_rd = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (busy && mem_we) n_wr++;
      if (busy && !mem_we && c <= 2560) n_rd++;
      if (fail && fail_cyc == 0) fail_cyc = c;
      if (done) begin
        done_cyc = c;
        break;
      end
      start = (c == pulse_at);
      if (c == rst_at) begin
        #1 rst = 1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        return;
      end
      @(negedge clk);
    end
    start = 0;
    if (done_cyc == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
  endtask

  initial begin
    int fc, dc, nw, nr, b, pulse;
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    chk_en = 1;
    repeat (5) @(negedge clk);

    // fault-free
    run_test(0, 0, fc, dc, nw, nr);
    check("clean_done_cyc", dc, 2562);
    check("clean_fail_cyc", fc, 0);
    check("clean_writes", nw, 1280);
    check("clean_reads", nr, 1280);

    // 0x37 bit 2 stuck-at-1
    f_en = 1; f_addr = 8'h37; f_mask = 4'b0100; f_val = 4'b0100;
    run_test(0, 0, fc, dc, nw, nr);
    check("sa1_fail_cyc", fc, 369);
    check("sa1_done_cyc", dc, 2562);
    check("sa1_fail_addr", 32'(fail_addr), 32'h37);
    check("sa1_fail_elem", 32'(fail_elem), 1);
    check("sa1_fail_data", 32'(fail_data), 32'b0100);

    // restart from DONE with the fault removed
    f_en = 0;
    run_test(0, 0, fc, dc, nw, nr);
    check("restart_fail_cyc", fc, 0);
    check("restart_done_cyc", dc, 2562);
    check("restart_fail", 32'(fail), 0);

    // 0xFF bit 0 stuck-at-0: first fail in E2 r1, E4 must not overwrite
    f_en = 1; f_addr = 8'hFF; f_mask = 4'b0001; f_val = 4'b0000;
    run_test(0, 0, fc, dc, nw, nr);
    check("sa0_fail_cyc", fc, 1281);
    check("sa0_done_cyc", dc, 2562);
    check("sa0_fail_addr", 32'(fail_addr), 32'hFF);
    check("sa0_fail_elem", 32'(fail_elem), 2);
    check("sa0_fail_data", 32'(fail_data), 32'b0001);

    // start pulsed while busy is ignored
    f_en = 0;
    run_test(500, 0, fc, dc, nw, nr);
    check("midstart_done_cyc", dc, 2562);

    // reset mid-run, idle, then clean run
    run_test(0, 1000, fc, dc, nw, nr);
    check("rst_no_done", dc, 0);
    repeat (20) @(negedge clk);
    check("post_rst_idle_busy", 32'(busy), 0);
    check("post_rst_idle_done", 32'(done), 0);
    run_test(0, 0, fc, dc, nw, nr);
    check("post_rst_done_cyc", dc, 2562);
    check("post_rst_fail", 32'(fail), 0);

    // random faults, gaps and stray start pulses
    for (int r = 0; r < 4; r++) begin
      f_en = ($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, 255);
      b = $urandom_range(0, 3);
      f_mask = 4'b0001 << b;
      f_val = $urandom_range(0, 1) ? f_mask : 4'h0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse = $urandom_range(0, 1) ? $urandom_range(2, 2500) : 0;
      run_test(pulse, 0, fc, dc, nw, nr);
      check("rand_done_cyc", dc, 2562);
      check("rand_writes", nw, 1280);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
